learn_sequencer: RTL and testbench

- Upstream controller for weight_change. It turns one learning request, a per-output-neuron fire mask, into a series of weight-update passes, one pass per selected output neuron.
- For each pass it drives start_wch, spike_hold, the ip_select sweep 0..N1-1, the neuron/bank select and the learning rates del_w_plus/del_w_minus.
- Between passes it waits for valid_wch.
- Owns learning-rate storage and periodic rate decay.

---
 rtl/learn_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_learn_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/learn_sequencer.sv
// rtl/learn_sequencer.sv - turns a fire-mask learning request into per-neuron weight_change passes
//
// Purpose: for each selected output neuron, issue one weight-update pass to
// weight_change (start pulse, potentiate/depress flag, input-address sweep,
// bank select, learning rates), then wait for its completion pulse. Also owns
// the learning-rate registers and their periodic decay.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   learn_req, fire_mask       one-cycle request and the neurons that spiked
//   valid_wch                  pass-complete pulse from weight_change
//   eta_load, eta_*_in         rate load, accepted only while idle
//   start_wch                  one-cycle pass start (ip_select is 0 that cycle)
//   spike_hold                 1 = potentiate, 0 = depress
//   ip_select                  input index / weight read address
//   neuron_sel                 active neuron bank
//   del_w_plus, del_w_minus    current learning rates, signed Q(W-12).12
//   busy                       high whenever not idle
//   learn_done                 one-cycle pulse when a request finishes
//   req_dropped                one-cycle pulse: request arrived while busy
//   wch_timeout                one-cycle pulse: a pass was abandoned
module learn_sequencer #(
  parameter int N             = 8,
  parameter int N1            = 784,
  parameter int W             = 24,
  parameter int DEPRESS_ALL   = 1,
  parameter int ETA_PLUS_INIT = 256,
  parameter int ETA_MINUS_INIT = 512,
  parameter int ETA_MIN       = 16,
  parameter int DECAY_PERIOD  = 64,
  parameter int DECAY_SHIFT   = 4,
  parameter int TIMEOUT       = 2048
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 learn_req,
  input  logic [N-1:0]         fire_mask,
  input  logic                 valid_wch,
  input  logic                 eta_load,
  input  logic [W-1:0]         eta_plus_in,
  input  logic [W-1:0]         eta_minus_in,
  output logic                 start_wch,
  output logic                 spike_hold,
  output logic [9:0]           ip_select,
  output logic [$clog2(N)-1:0] neuron_sel,
  output logic [W-1:0]         del_w_plus,
  output logic [W-1:0]         del_w_minus,
  output logic                 busy,
  output logic                 learn_done,
  output logic                 req_dropped,
  output logic                 wch_timeout
);

  localparam int SW = $clog2(N);
  localparam int JW = $clog2(N + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(DECAY_PERIOD + 2);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SCAN  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] SWEEP = 3'd3;
  localparam logic [2:0] WAIT  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic signed [W-1:0] ETA_MIN_S = W'(ETA_MIN);

  logic [2:0]    state;
  logic [N-1:0]  mask;
  logic [JW-1:0] j;
  logic [SW-1:0] jl;
  logic [TW-1:0] tcnt;
  logic [RW-1:0] req_cnt;

  assign jl = j[SW-1:0];

  // eta - eta/2^shift with an arithmetic shift, floored at ETA_MIN.
  function automatic logic [W-1:0] decay(input logic [W-1:0] eta);
    logic signed [W-1:0] s;
    logic signed [W-1:0] d;
    s = $signed(eta);
    d = s - (s >>> DECAY_SHIFT);
    if (d < ETA_MIN_S) d = ETA_MIN_S;
    return $unsigned(d);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mask        <= '0;
      j           <= '0;
      tcnt        <= '0;
      req_cnt     <= '0;
      start_wch   <= 1'b0;
      spike_hold  <= 1'b0;
      ip_select   <= '0;
      neuron_sel  <= '0;
      del_w_plus  <= W'(ETA_PLUS_INIT);
      del_w_minus <= W'(ETA_MINUS_INIT);
      busy        <= 1'b0;
      learn_done  <= 1'b0;
      req_dropped <= 1'b0;
      wch_timeout <= 1'b0;
    end else begin
      start_wch   <= 1'b0;
      learn_done  <= 1'b0;
      req_dropped <= 1'b0;
      wch_timeout <= 1'b0;

      if (learn_req && state != IDLE) req_dropped <= 1'b1;

      case (state)
        IDLE: begin
          // Load first so a request in the same cycle runs with the new rates.
          if (eta_load) begin
            del_w_plus  <= eta_plus_in;
            del_w_minus <= eta_minus_in;
          end
          if (learn_req) begin
            mask  <= fire_mask;
            j     <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end

        SCAN: begin
          if (j == JW'(N)) begin
            learn_done <= 1'b1;
            state      <= DONE;
          end else if (mask[jl] || DEPRESS_ALL != 0) begin
            spike_hold <= mask[jl];
            neuron_sel <= jl;
            start_wch  <= 1'b1;
            ip_select  <= '0;
            state      <= START;
          end else if (j == JW'(N - 1)) begin
            // Skipping the last neuron ends the request without an extra scan.
            j          <= j + JW'(1);
            learn_done <= 1'b1;
            state      <= DONE;
          end else begin
            j <= j + JW'(1);
          end
        end

        START: begin
          ip_select <= 10'd1;
          state     <= SWEEP;
        end

        SWEEP: begin
          if (ip_select == 10'(N1 - 1)) begin
            ip_select <= '0;
            tcnt      <= '0;
            state     <= WAIT;
          end else begin
            ip_select <= ip_select + 10'd1;
          end
        end

        WAIT: begin
          if (valid_wch) begin
            j     <= j + JW'(1);
            tcnt  <= '0;
            state <= SCAN;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            wch_timeout <= 1'b1;
            j           <= j + JW'(1);
            tcnt        <= '0;
            state       <= SCAN;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (DECAY_PERIOD != 0) begin
            if (req_cnt == RW'(DECAY_PERIOD - 1)) begin
              req_cnt     <= '0;
              del_w_plus  <= decay(del_w_plus);
              del_w_minus <= decay(del_w_minus);
            end else begin
              req_cnt <= req_cnt + RW'(1);
            end
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_learn_sequencer.sv
// tb/tb_learn_sequencer.sv - self-checking bench for learn_sequencer
module tb_learn_sequencer;

  localparam int N  = 8;
  localparam int N1 = 16;
  localparam int W  = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // shared rate-load inputs
  logic         eta_load = 1'b0;
  logic [W-1:0] eta_plus_in = '0;
  logic [W-1:0] eta_minus_in = '0;

  // instance a: DEPRESS_ALL=0, decay every 2 requests
  logic         req_a = 1'b0;
  logic [N-1:0] mask_a = '0;
  logic         valid_a = 1'b0;
  logic         start_a, spike_a, busy_a, done_a, drop_a, to_a;
  logic [9:0]   ip_a;
  logic [2:0]   sel_a;
  logic [W-1:0] dwp_a, dwm_a;

  // instance b: DEPRESS_ALL=1, no decay
  logic         req_b = 1'b0;
  logic [N-1:0] mask_b = '0;
  logic         valid_b = 1'b0;
  logic         start_b, spike_b, busy_b, done_b, drop_b, to_b;
  logic [9:0]   ip_b;
  logic [2:0]   sel_b;
  logic [W-1:0] dwp_b, dwm_b;

  learn_sequencer #(.N(N), .N1(N1), .W(W), .DEPRESS_ALL(0), .ETA_PLUS_INIT(256),
    .ETA_MINUS_INIT(512), .ETA_MIN(16), .DECAY_PERIOD(2), .DECAY_SHIFT(4), .TIMEOUT(32)) dut_a (
    .clk(clk), .rst(rst), .learn_req(req_a), .fire_mask(mask_a), .valid_wch(valid_a),
    .eta_load(eta_load), .eta_plus_in(eta_plus_in), .eta_minus_in(eta_minus_in),
    .start_wch(start_a), .spike_hold(spike_a), .ip_select(ip_a), .neuron_sel(sel_a),
    .del_w_plus(dwp_a), .del_w_minus(dwm_a), .busy(busy_a), .learn_done(done_a),
    .req_dropped(drop_a), .wch_timeout(to_a));

  learn_sequencer #(.N(N), .N1(N1), .W(W), .DEPRESS_ALL(1), .ETA_PLUS_INIT(256),
    .ETA_MINUS_INIT(512), .ETA_MIN(16), .DECAY_PERIOD(0), .DECAY_SHIFT(4), .TIMEOUT(32)) dut_b (
    .clk(clk), .rst(rst), .learn_req(req_b), .fire_mask(mask_b), .valid_wch(valid_b),
    .eta_load(eta_load), .eta_plus_in(eta_plus_in), .eta_minus_in(eta_minus_in),
    .start_wch(start_b), .spike_hold(spike_b), .ip_select(ip_b), .neuron_sel(sel_b),
    .del_w_plus(dwp_b), .del_w_minus(dwm_b), .busy(busy_b), .learn_done(done_b),
    .req_dropped(drop_b), .wch_timeout(to_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // weight_change models: valid_wch 5 cycles after the last sweep address
  logic model_on_a = 1'b1;
  int   cd_a = 0;
  int   cd_b = 0;
  always @(negedge clk) begin
    if (rst) begin
      cd_a = 0; valid_a = 1'b0;
    end else if (model_on_a && busy_a && ip_a == 10'(N1 - 1)) begin
      cd_a = 5; valid_a = 1'b0;
    end else if (cd_a != 0) begin
      cd_a--; valid_a = (cd_a == 0);
    end else begin
      valid_a = 1'b0;
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      cd_b = 0; valid_b = 1'b0;
    end else if (busy_b && ip_b == 10'(N1 - 1)) begin
      cd_b = 5; valid_b = 1'b0;
    end else if (cd_b != 0) begin
      cd_b--; valid_b = (cd_b == 0);
    end else begin
      valid_b = 1'b0;
    end
  end

  // monitor a: pass bookkeeping and sweep contiguity
  int starts_a = 0, done_cnt_a = 0, drop_cnt_a = 0, to_cnt_a = 0;
  int addr_err_a = 0, order_err_a = 0, addrs_a = 0, last_sel_a = -1;
  int exp_ip_a = 0, last15_a = 0, to_gap_a = 0;
  bit sweeping_a = 1'b0;
  logic [N-1:0] sel_set_a = '0, spk_set_a = '0;
  always @(negedge clk) begin
    if (rst) begin
      sweeping_a = 1'b0;
    end else begin
      if (req_a && !busy_a) begin
        sel_set_a = '0; spk_set_a = '0; last_sel_a = -1;
      end
      if (start_a) begin
        starts_a++;
        sel_set_a[sel_a] = 1'b1;
        if (spike_a) spk_set_a[sel_a] = 1'b1;
        if (int'(sel_a) <= last_sel_a) order_err_a++;
        last_sel_a = int'(sel_a);
        if (ip_a != 0) addr_err_a++;
        addrs_a++;
        exp_ip_a = 1;
        sweeping_a = 1'b1;
      end else if (sweeping_a) begin
        if (int'(ip_a) != exp_ip_a) addr_err_a++;
        addrs_a++;
        if (exp_ip_a == N1 - 1) begin
          sweeping_a = 1'b0;
          last15_a = cyc;
        end else begin
          exp_ip_a++;
        end
      end
      if (done_a) done_cnt_a++;
      if (drop_a) drop_cnt_a++;
      if (to_a) begin
        to_cnt_a++;
        to_gap_a = cyc - last15_a;
      end
    end
  end

  // monitor b
  int starts_b = 0, done_cnt_b = 0;
  logic [N-1:0] sel_set_b = '0, spk_set_b = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (start_b) begin
        starts_b++;
        sel_set_b[sel_b] = 1'b1;
        if (spike_b) spk_set_b[sel_b] = 1'b1;
      end
      if (done_b) done_cnt_b++;
    end
  end

  task automatic go_a(input logic [N-1:0] m);
    mask_a = m;
    req_a  = 1'b1;
    tick;
    req_a  = 1'b0;
  endtask

  task automatic wait_done_a(input string nm, input int maxc);
    int s = done_cnt_a;
    int n = 0;
    while (done_cnt_a == s && n < maxc) begin
      tick;
      n++;
    end
    chk(nm, done_cnt_a - s, 1);
    tick;  // step into IDLE, where decayed rates are visible
  endtask

  task automatic wait_ip_a(input logic [9:0] v);
    int n = 0;
    while (ip_a != v && n < 100) begin
      tick;
      n++;
    end
    chk("reach_ip", ip_a, v);
  endtask

  typedef struct {
    logic [N-1:0] mask;
    int           passes;
    logic [N-1:0] sels;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int s_st, s_dr, s_to, s_ae, s_ad, n;

    tbl[0] = '{mask: 8'b0000_0101, passes: 2, sels: 8'b0000_0101};
    tbl[1] = '{mask: 8'h80,        passes: 1, sels: 8'h80};
    tbl[2] = '{mask: 8'hFF,        passes: 8, sels: 8'hFF};
    tbl[3] = '{mask: 8'h00,        passes: 0, sels: 8'h00};

    // reset state
    repeat (3) tick;
    chk("rst_start", start_a, 0);
    chk("rst_ip", ip_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_spike", spike_a, 0);
    chk("rst_sel", sel_a, 0);
    chk("rst_dwp", dwp_a, 256);
    chk("rst_dwm", dwm_a, 512);
    chk("rst_dwp_b", dwp_b, 256);
    rst = 1'b0;
    tick;

    // table-driven requests on instance a
    for (int i = 0; i < 4; i++) begin
      s_st = starts_a;
      s_ae = addr_err_a;
      go_a(tbl[i].mask);
      wait_done_a($sformatf("tbl%0d_done", i), 500);
      chk($sformatf("tbl%0d_passes", i), starts_a - s_st, tbl[i].passes);
      chk($sformatf("tbl%0d_sels", i), sel_set_a, tbl[i].sels);
      chk($sformatf("tbl%0d_spike", i), spk_set_a, tbl[i].sels);
      chk($sformatf("tbl%0d_addr", i), addr_err_a - s_ae, 0);
      chk($sformatf("tbl%0d_order", i), order_err_a, 0);
      chk($sformatf("tbl%0d_busy", i), busy_a, 0);
    end
    // four requests, decay every two: 256->240->225, 512->480->450
    chk("decay4_dwp", dwp_a, 225);
    chk("decay4_dwm", dwm_a, 450);

    // empty mask: N scan cycles then learn_done, no start
    s_st = starts_a;
    go_a(8'h00);
    n = 0;
    while (!done_a && n < 50) begin
      tick;
      n++;
    end
    chk("empty_latency", n, 8);
    chk("empty_starts", starts_a - s_st, 0);
    tick;

    // request while busy is dropped without disturbing the pass
    s_st = starts_a; s_dr = drop_cnt_a; s_ae = addr_err_a; s_ad = addrs_a;
    go_a(8'h01);
    wait_ip_a(10'd5);
    mask_a = 8'hFF;
    req_a  = 1'b1;
    tick;
    req_a  = 1'b0;
    wait_done_a("drop_done", 200);
    chk("drop_pulses", drop_cnt_a - s_dr, 1);
    chk("drop_passes", starts_a - s_st, 1);
    chk("drop_addrs", addrs_a - s_ad, N1);
    chk("drop_addr_err", addr_err_a - s_ae, 0);

    // weight_change never answers: each pass times out after 32 WAIT cycles
    model_on_a = 1'b0;
    s_st = starts_a; s_to = to_cnt_a;
    go_a(8'h03);
    wait_done_a("to_done", 300);
    chk("to_pulses", to_cnt_a - s_to, 2);
    chk("to_passes", starts_a - s_st, 2);
    chk("to_gap", to_gap_a, 33);
    model_on_a = 1'b1;

    // reset in the middle of a sweep
    go_a(8'h01);
    wait_ip_a(10'd7);
    rst = 1'b1;
    #1;
    chk("mid_rst_ip", ip_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_spike", spike_a, 0);
    chk("mid_rst_dwp", dwp_a, 256);
    chk("mid_rst_dwm", dwm_a, 512);
    tick;
    tick;
    rst = 1'b0;
    tick;
    go_a(8'h01);
    chk("restart_nostart", start_a, 0);
    tick;
    chk("restart_start", start_a, 1);
    chk("restart_sel", sel_a, 0);
    chk("restart_ip", ip_a, 0);
    wait_done_a("restart_done", 200);

    // decay after two requests (counter restarted by the reset above)
    chk("pre_decay_dwp", dwp_a, 256);
    go_a(8'h00);
    wait_done_a("decay_done", 100);
    chk("decay_dwp", dwp_a, 240);
    chk("decay_dwm", dwm_a, 480);

    // load while idle, load while busy ignored, then decay 20 -> 19
    eta_plus_in = 24'd20; eta_minus_in = 24'd20; eta_load = 1'b1;
    tick;
    eta_load = 1'b0;
    chk("load_dwp", dwp_a, 20);
    chk("load_dwm", dwm_a, 20);
    go_a(8'h01);
    tick;
    eta_plus_in = 24'd100; eta_minus_in = 24'd100; eta_load = 1'b1;
    tick;
    eta_load = 1'b0;
    wait_done_a("busyload_done", 200);
    chk("busyload_dwp", dwp_a, 20);
    go_a(8'h00);
    wait_done_a("decay2_done", 100);
    chk("decay2_dwp", dwp_a, 19);
    chk("decay2_dwm", dwm_a, 19);

    // instance b: depress-all pass pattern
    mask_b = 8'h01;
    req_b  = 1'b1;
    tick;
    req_b  = 1'b0;
    n = 0;
    while (done_cnt_b == 0 && n < 1000) begin
      tick;
      n++;
    end
    chk("b_done", done_cnt_b, 1);
    chk("b_starts", starts_b, 8);
    chk("b_sels", sel_set_b, 8'hFF);
    chk("b_spike", spk_set_b, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
